// File: rtl/delay_rx_pkg.sv
// Shared types and sizing helpers for the delay-stage receive buffer.
package delay_rx_pkg;

    localparam int DATA_W        = 16;
    localparam int OVF_CNT_W_DEF = 8;

    typedef logic [DATA_W-1:0] sample_t;

    // Pointer width for a power-of-two depth; never narrower than one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/delay_rx_mem.sv
// Sample storage: one synchronous write port, one asynchronous read port, no reset.
module delay_rx_mem
    import delay_rx_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [ptr_w(DEPTH)-1:0] waddr,
    input  sample_t                 wdata,
    input  logic [ptr_w(DEPTH)-1:0] raddr,
    output sample_t                 rdata
);

    sample_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/delay_data_rx_buffer.sv
// Elastic receive buffer: strobe-qualified samples in, valid/ready out, overruns counted.
// Optional macro DELAY_RX_LEVEL_EN adds a level output (FIFO words + output register).
module delay_data_rx_buffer
    import delay_rx_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int OVF_CNT_W = OVF_CNT_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  sample_t                       data_in,
    input  logic                          en,
    output logic                          full,
    output sample_t                       data_out,
    output logic                          valid,
    input  logic                          ready,
    output logic                          ovf,
    output logic [OVF_CNT_W-1:0]          ovf_cnt,
`ifdef DELAY_RX_LEVEL_EN
    output logic [$clog2(DEPTH+2)-1:0]    level,
`endif
    input  logic                          clr_ovf
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 full_q, full_d;
    logic                 valid_q, valid_d;
    sample_t              data_out_q, data_out_d;
    logic                 ovf_q, ovf_d;
    logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

    logic    push, pop, drop;
    sample_t head;

    delay_rx_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (data_in),
        .raddr (rd_ptr_q),
        .rdata (head)
    );

    always_comb begin
        // Space is judged on the pre-edge count: a same-cycle pop never makes room.
        push = en && !flush && (count_q != DEPTH_C);
        drop = en && !flush && (count_q == DEPTH_C);
        pop  = !flush && (count_q != '0) && (!valid_q || ready);

        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        data_out_d = pop ? head : data_out_q;

        valid_d = valid_q;
        if (pop) begin
            valid_d = 1'b1;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            valid_d  = 1'b0;
        end

        full_d = (count_d == DEPTH_C);

        ovf_d     = ovf_q;
        ovf_cnt_d = ovf_cnt_q;
        if (drop) begin
            ovf_d     = 1'b1;
            ovf_cnt_d = clr_ovf       ? OVF_CNT_W'(1)
                      : (&ovf_cnt_q)  ? ovf_cnt_q
                      :                 ovf_cnt_q + OVF_CNT_W'(1);
        end else if (clr_ovf) begin
            ovf_d     = 1'b0;
            ovf_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            valid_q    <= 1'b0;
            data_out_q <= '0;
            ovf_q      <= 1'b0;
            ovf_cnt_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            valid_q    <= valid_d;
            data_out_q <= data_out_d;
            ovf_q      <= ovf_d;
            ovf_cnt_q  <= ovf_cnt_d;
        end
    end

    assign full     = full_q;
    assign valid    = valid_q;
    assign data_out = data_out_q;
    assign ovf      = ovf_q;
    assign ovf_cnt  = ovf_cnt_q;

`ifdef DELAY_RX_LEVEL_EN
    localparam int LVL_W = $clog2(DEPTH + 2);
    assign level = LVL_W'(count_q) + LVL_W'(valid_q);
`endif

endmodule

// File: tb/tb_delay_data_rx_buffer.sv
// Directed and randomized checks for delay_data_rx_buffer (DEPTH=8, 8-bit overflow counter).
module tb_delay_data_rx_buffer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n, flush, en, ready, clr_ovf;
    logic [15:0] data_in;
    logic        full, valid, ovf;
    logic [15:0] data_out;
    logic [7:0]  ovf_cnt;
`ifdef DELAY_RX_LEVEL_EN
    logic [3:0]  level;
`endif

    int checks   = 0;
    int failures = 0;

    delay_data_rx_buffer #(.DEPTH(DEPTH), .OVF_CNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .data_in  (data_in),
        .en       (en),
        .full     (full),
        .data_out (data_out),
        .valid    (valid),
        .ready    (ready),
        .ovf      (ovf),
        .ovf_cnt  (ovf_cnt),
`ifdef DELAY_RX_LEVEL_EN
        .level    (level),
`endif
        .clr_ovf  (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; flush = 1'b0; en = 1'b0; ready = 1'b0; clr_ovf = 1'b0; data_in = '0;
        tick();
        checks++;
        if ({valid, full, ovf, ovf_cnt, data_out} !== 27'h0) begin
            failures++;
            $display("FAIL reset_state: got valid=%b full=%b ovf=%b cnt=%0d data=%h, want all zero",
                     valid, full, ovf, ovf_cnt, data_out);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: valid=%b want 0", valid);
        end
    endtask

    task automatic test_single_word;
        ready = 1'b1; en = 1'b1; data_in = 16'hA5A5;
        tick();
        en = 1'b0;
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL single_early: valid=%b want 0 after first edge", valid);
        end
        tick();
        checks++;
        if (valid !== 1'b1 || data_out !== 16'hA5A5) begin
            failures++;
            $display("FAIL single_out: valid=%b data=%h want 1/a5a5", valid, data_out);
        end
        tick();
        checks++;
        if (valid !== 1'b0 || data_out !== 16'hA5A5) begin
            failures++;
            $display("FAIL single_drain: valid=%b data=%h want 0/a5a5", valid, data_out);
        end
    endtask

    task automatic test_stall_drain;
        ready = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            en = 1'b1; data_in = 16'(i);
            tick();
        end
        en = 1'b0;
        checks++;
        if (valid !== 1'b1 || data_out !== 16'd1 || full !== 1'b1 || ovf !== 1'b1 || ovf_cnt !== 8'd3) begin
            failures++;
            $display("FAIL stall_state: valid=%b data=%0d full=%b ovf=%b cnt=%0d want 1/1/1/1/3",
                     valid, data_out, full, ovf, ovf_cnt);
        end
`ifdef DELAY_RX_LEVEL_EN
        checks++;
        if (level !== 4'd9) begin
            failures++;
            $display("FAIL stall_level: level=%0d want 9", level);
        end
`endif
        ready = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            checks++;
            if (valid !== 1'b1 || data_out !== 16'(i)) begin
                failures++;
                $display("FAIL drain_word: valid=%b data=%0d want 1/%0d", valid, data_out, i);
            end
            tick();
        end
        checks++;
        if (valid !== 1'b0 || full !== 1'b0) begin
            failures++;
            $display("FAIL drain_empty: valid=%b full=%b want 0/0", valid, full);
        end
    endtask

    task automatic test_full_pop_push;
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            en = 1'b1; data_in = 16'h0100 + 16'(i);
            tick();
        end
        checks++;
        if (full !== 1'b1 || valid !== 1'b1 || ovf_cnt !== 8'd0) begin
            failures++;
            $display("FAIL fpp_setup: full=%b valid=%b cnt=%0d want 1/1/0", full, valid, ovf_cnt);
        end
        ready = 1'b1; en = 1'b1; data_in = 16'h00FF;
        tick();
        en = 1'b0;
        checks++;
        if (ovf_cnt !== 8'd1 || full !== 1'b0 || data_out !== 16'h0102 || valid !== 1'b1) begin
            failures++;
            $display("FAIL fpp_drop: cnt=%0d full=%b data=%h valid=%b want 1/0/0102/1",
                     ovf_cnt, full, data_out, valid);
        end
        for (int i = 2; i <= 9; i++) begin
            checks++;
            if (valid !== 1'b1 || data_out !== 16'h0100 + 16'(i)) begin
                failures++;
                $display("FAIL fpp_drain: valid=%b data=%h want 1/%h", valid, data_out, 16'h0100 + 16'(i));
            end
            tick();
        end
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL fpp_extra: valid=%b data=%h want empty", valid, data_out);
        end
    endtask

    task automatic test_saturation;
        ready = 1'b0; clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 309; i++) begin
            data_in = 16'(i);
            tick();
        end
        en = 1'b0;
        checks++;
        if (ovf_cnt !== 8'd255 || ovf !== 1'b1) begin
            failures++;
            $display("FAIL sat_cnt: cnt=%0d ovf=%b want 255/1", ovf_cnt, ovf);
        end
        clr_ovf = 1'b1;
        tick();
        checks++;
        if (ovf_cnt !== 8'd0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL clr_alone: cnt=%0d ovf=%b want 0/0", ovf_cnt, ovf);
        end
        en = 1'b1;
        tick();
        en = 1'b0; clr_ovf = 1'b0;
        checks++;
        if (ovf_cnt !== 8'd1 || ovf !== 1'b1) begin
            failures++;
            $display("FAIL clr_vs_drop: cnt=%0d ovf=%b want 1/1", ovf_cnt, ovf);
        end
    endtask

    task automatic test_flush;
        flush = 1'b1;
        tick();
        flush = 1'b0; ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            en = 1'b1; data_in = 16'h0200 + 16'(i);
            tick();
        end
        en = 1'b0;
        checks++;
        if (valid !== 1'b1 || data_out !== 16'h0200) begin
            failures++;
            $display("FAIL flush_setup: valid=%b data=%h want 1/0200", valid, data_out);
        end
        flush = 1'b1; en = 1'b1; data_in = 16'hDEAD;
        tick();
        flush = 1'b0; en = 1'b0;
        checks++;
        if (valid !== 1'b0 || full !== 1'b0 || ovf_cnt !== 8'd1) begin
            failures++;
            $display("FAIL flush_clear: valid=%b full=%b cnt=%0d want 0/0/1", valid, full, ovf_cnt);
        end
`ifdef DELAY_RX_LEVEL_EN
        checks++;
        if (level !== 4'd0) begin
            failures++;
            $display("FAIL flush_level: level=%0d want 0", level);
        end
`endif
        ready = 1'b1;
        tick();
        tick();
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_residue: valid=%b data=%h want empty", valid, data_out);
        end
        en = 1'b1; data_in = 16'h1234;
        tick();
        en = 1'b0;
        tick();
        checks++;
        if (valid !== 1'b1 || data_out !== 16'h1234) begin
            failures++;
            $display("FAIL flush_after: valid=%b data=%h want 1/1234", valid, data_out);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            en = 1'b1; data_in = 16'h0300 + 16'(i);
            tick();
        end
        en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (valid !== 1'b0 || data_out !== 16'h0 || full !== 1'b0 || ovf !== 1'b0 || ovf_cnt !== 8'd0) begin
            failures++;
            $display("FAIL async_reset: valid=%b data=%h full=%b ovf=%b cnt=%0d want all zero",
                     valid, data_out, full, ovf, ovf_cnt);
        end
        #1 rst_n = 1'b1;
        @(negedge clk);
        ready = 1'b1; en = 1'b1; data_in = 16'hBEEF;
        tick();
        en = 1'b0;
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_early: valid=%b want 0", valid);
        end
        tick();
        checks++;
        if (valid !== 1'b1 || data_out !== 16'hBEEF) begin
            failures++;
            $display("FAIL post_reset_word: valid=%b data=%h want 1/beef", valid, data_out);
        end
        tick();
    endtask

    task automatic test_random;
        logic [15:0] mq[$];
        logic        mv;
        logic [15:0] md;
        int          drops;
        logic        do_push, do_pop;
        flush = 1'b1; clr_ovf = 1'b1;
        tick();
        flush = 1'b0; clr_ovf = 1'b0;
        mv = 1'b0; md = 16'hBEEF; drops = 0;
        for (int c = 0; c < 3000; c++) begin
            checks++;
            if (valid !== mv || (mv && data_out !== md) || full !== (mq.size() == DEPTH)) begin
                failures++;
                $display("FAIL random_cycle%0d: valid=%b data=%h full=%b want %b/%h/%b",
                         c, valid, data_out, full, mv, md, mq.size() == DEPTH);
            end
            en      = ($urandom_range(99) < 50);
            ready   = (c < 2000) ? ($urandom_range(99) < 70) : ($urandom_range(99) < 20);
            data_in = 16'($urandom);
            do_push = en && (mq.size() < DEPTH);
            do_pop  = (mq.size() > 0) && (!mv || ready);
            if (en && !do_push) drops++;
            if (do_pop) begin
                md = mq.pop_front();
                mv = 1'b1;
            end else if (mv && ready) begin
                mv = 1'b0;
            end
            if (do_push) mq.push_back(data_in);
            tick();
        end
        en = 1'b0;
        checks++;
        if (ovf_cnt !== 8'((drops > 255) ? 255 : drops) || ovf !== (drops > 0)) begin
            failures++;
            $display("FAIL random_drops: cnt=%0d ovf=%b want %0d/%b",
                     ovf_cnt, ovf, (drops > 255) ? 255 : drops, drops > 0);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_stall_drain();
        test_full_pop_push();
        test_saturation();
        test_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
